tru_readout_receiver: RTL and testbench
=======================================

Name: tru_readout_receiver

Overview:
- Receiving end of the TRU strobed readout link.
- The link drives a data bus, an active-low transfer envelope (trsf) and a clock-gated, active-low data strobe (dstb).
- The block captures one frame of strobed words into a 32-entry buffer, checks framing, and exposes the frame to the downstream consumer through a read port.
- Sits at the readout-controller end of the link; test boards also use it as the loopback checker for the TRU transmitter.

Parameters:
- DATA_W, 16, width of the link data bus.
- FRAME_LEN, 30, expected strobes per frame (16 channel words, 12 summary words, 1 status word, 1 trailer word).
- TIMEOUT, 64, clk cycles allowed between consecutive strobes inside a frame.

Ports:
- clk  in  1  system clock; same clock as the transmitter.
- reset  in  1  synchronous, active-low reset.
- trsf  in  1  active-low transfer envelope from the link.
- dstb  in  1  active-low strobe; low only during the clk-low half-period of a valid word.
- data_in  in  DATA_W  link data bus; valid while dstb is low.
- rd_addr  in  5  buffer read address.
- rd_data  out  DATA_W  buffer word at rd_addr; 1-cycle read latency.
- frame_valid  out  1  a complete, well-formed frame is held.
- frame_err  out  1  the last frame was malformed.
- err_code  out  2  00 none, 01 short, 10 long, 11 timeout.
- word_count  out  6  strobes received in the current or last frame.
- frame_ack  in  1  consumer releases the frame; clears frame_valid and frame_err.

Behaviour:
- Strobe capture:
  - A single negedge-clk flop samples ~dstb, together with data_in into a DATA_W holding register.
  - All other logic is posedge clk.
  - A word is accepted at posedge when the negedge flop is set and the registered trsf is low.
- Registering: trsf is registered once (trsf_q); a frame start is trsf_q falling (1→0).
- Reset (reset=0 at posedge):
  - state=IDLE; frame_valid=0; frame_err=0; err_code=00; word_count=0.
  - Buffer contents are not cleared.
  - Reset mid-frame aborts the frame with no error reported.
- States:
  - IDLE:
    - On a frame start with frame_valid=0 → RECV; word_count=0, timer=0.
    - A frame start while frame_valid=1 → DROP (overrun: the previous frame is held).
  - RECV:
    - Each accepted word is written to buffer[word_count[4:0]] and word_count increments. The write and the increment occur on the same posedge.
    - Words beyond index 31 are not written, but word_count keeps counting and saturates at 63.
    - The timer resets on each accepted word and otherwise increments.
    - timer==TIMEOUT-1 → CHECK with err_code 11.
    - trsf_q rising → CHECK.
  - CHECK (exactly 1 cycle):
    - word_count==FRAME_LEN and no timeout: frame_valid=1, err_code=00.
    - word_count<FRAME_LEN: frame_err=1, err_code=01.
    - word_count>FRAME_LEN: frame_err=1, err_code=10.
    - Then → IDLE.
  - DROP: ignores strobes; trsf_q rising → IDLE. frame_valid stays 1 and the held buffer is untouched.
- frame_ack:
  - Clears frame_valid, frame_err and err_code to 00 on the next posedge.
  - If frame_ack coincides with the CHECK cycle, the CHECK result wins.
- Simultaneous events:
  - Strobe and trsf rising in the same cycle: the word is counted first, then → CHECK.
  - A strobe seen in IDLE (trsf_q high) is ignored.
- Buffer read: rd_data is registered from buffer[rd_addr] and is readable in any state. Reads during RECV return mixed old/new data; the consumer must wait for frame_valid.
- A frame of 30 words back-to-back gives frame_valid 3 cycles after trsf returns high (trsf register, RECV exit, CHECK).

Decomposition:
- Shared package tru_link_pkg:
  - State encodings IDLE/RECV/CHECK/DROP.
  - err_code constants.
  - FRAME_LEN.
  - Word-index boundaries: 0–15 channel, 16–27 summary, 28 status, 29 trailer. Shared with the transmitter.
- One sub-module: tru_frame_buffer, a 32×DATA_W simple dual-port RAM with synchronous write and registered read.

Test Plan:
- Nominal frame: trsf low, 30 strobes carrying data 0x0100+i, trsf high → frame_valid=1, err_code=00, word_count=30; rd_addr=5 returns 0x0105; rd_addr=29 returns 0x011D.
- Short frame: 20 strobes → frame_err=1, err_code=01, word_count=20, frame_valid=0.
- Long frame: 34 strobes → err_code=10, word_count=34; buffer[31] holds word 31 and words 32–33 are not written.
- Timeout: 10 strobes, then a 64-cycle gap with trsf held low → err_code=11 exactly 64 cycles after the last strobe; state returns to IDLE.
- Overrun: a second frame starts before frame_ack → DROP; the first frame's buffer is unchanged and frame_valid stays 1. After frame_ack, a third frame is received normally.
- Reset at word 12 of a frame → all outputs 0; the next full frame is received cleanly with word_count=30.

Source files
------------

// File: rtl/tru_link_pkg.sv
// Shared definitions for the TRU strobed readout link: receiver FSM states,
// error codes and the frame word layout, common to transmitter and receiver.
package tru_link_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRecv  = 2'd1,
    StCheck = 2'd2,
    StDrop  = 2'd3
  } state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrShort   = 2'b01;
  localparam logic [1:0] ErrLong    = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  // Frame layout: channel words, summary words, one status word, one trailer.
  localparam int unsigned NumChanWords = 16;
  localparam int unsigned NumSumWords  = 12;
  localparam int unsigned ChanBase     = 0;
  localparam int unsigned SumBase      = ChanBase + NumChanWords;
  localparam int unsigned StatusIdx    = SumBase + NumSumWords;
  localparam int unsigned TrailerIdx   = StatusIdx + 1;
  localparam int unsigned FRAME_LEN    = TrailerIdx + 1;

  localparam int unsigned BufAddrW = 5;

endpackage

// File: rtl/tru_frame_buffer.sv
// Frame buffer: simple dual-port RAM, synchronous write, registered read.
module tru_frame_buffer #(
  parameter int unsigned DataW = 16,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tru_readout_receiver.sv
// Receiving end of the TRU strobed readout link: captures one frame into a
// 32-word buffer, checks its length and inter-strobe timing, and holds it for the consumer.
module tru_readout_receiver #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = tru_link_pkg::FRAME_LEN,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trsf,
  input  logic              dstb,
  input  logic [DATA_W-1:0] data_in,
  input  logic [4:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [5:0]        word_count,
  input  logic              frame_ack
);

  import tru_link_pkg::*;

  localparam int unsigned   TimerW    = $clog2(TIMEOUT);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);
  localparam logic [5:0]    FrameLenW = 6'(FRAME_LEN);

  // The strobe is only low while clk is low, so it is caught on the falling edge.
  logic              stb_q;
  logic [DATA_W-1:0] hold_q;

  always_ff @(negedge clk) begin
    stb_q  <= ~dstb;
    hold_q <= data_in;
  end

  // Left out of reset so a frame in flight during reset leaves no false start edge.
  logic trsf_q, trsf_qq;

  always_ff @(posedge clk) begin
    trsf_q  <= trsf;
    trsf_qq <= trsf_q;
  end

  state_e            state_q, state_d;
  logic [5:0]        wc_q, wc_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              tout_q, tout_d;
  logic              accept, frame_start, buf_we;

  assign accept      = stb_q & ~trsf_q;
  assign frame_start = trsf_qq & ~trsf_q;

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    timer_d = timer_q;
    valid_d = valid_q;
    err_d   = err_q;
    code_d  = code_q;
    tout_d  = tout_q;
    buf_we  = 1'b0;

    // Ack first so that a CHECK result or timeout in the same cycle overrides it.
    if (frame_ack) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      code_d  = ErrNone;
    end

    case (state_q)
      StIdle: begin
        if (frame_start) begin
          if (valid_q) begin
            state_d = StDrop;
          end else begin
            state_d = StRecv;
            wc_d    = '0;
            timer_d = '0;
            tout_d  = 1'b0;
          end
        end
      end
      StRecv: begin
        if (accept) begin
          buf_we  = ~wc_q[5];
          timer_d = '0;
          if (wc_q != 6'd63) wc_d = wc_q + 6'd1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
        if (trsf_q) begin
          state_d = StCheck;
        end else if (!accept && timer_q == TimerMax) begin
          state_d = StCheck;
          tout_d  = 1'b1;
          code_d  = ErrTimeout;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (tout_q) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          code_d  = ErrTimeout;
        end else if (wc_q == FrameLenW) begin
          valid_d = 1'b1;
          err_d   = 1'b0;
          code_d  = ErrNone;
        end else begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          code_d  = (wc_q < FrameLenW) ? ErrShort : ErrLong;
        end
      end
      StDrop: begin
        if (trsf_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      wc_q    <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      tout_q  <= tout_d;
    end
  end

  tru_frame_buffer #(
    .DataW(DATA_W),
    .AddrW(BufAddrW)
  ) u_frame_buffer (
    .clk_i  (clk),
    .we_i   (buf_we),
    .waddr_i(wc_q[4:0]),
    .wdata_i(hold_q),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign word_count  = wc_q;

endmodule

// File: tb/tb_tru_readout_receiver.sv
// Randomized bench for tru_readout_receiver against a frame-level reference model.
module tb_tru_readout_receiver;

  localparam int DW   = 16;
  localparam int FLEN = 30;

  logic          clk = 1'b0;
  logic          reset, trsf, dstb, frame_ack;
  logic [DW-1:0] data_in;
  logic [4:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          frame_valid, frame_err;
  logic [1:0]    err_code;
  logic [5:0]    word_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] model_mem [32];
  logic [DW-1:0] sent_q [$];

  always #5 clk = ~clk;

  tru_readout_receiver #(
    .DATA_W   (DW),
    .FRAME_LEN(FLEN),
    .TIMEOUT  (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trsf       (trsf),
    .dstb       (dstb),
    .data_in    (data_in),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .word_count (word_count),
    .frame_ack  (frame_ack)
  );

  function automatic logic [1:0] exp_code(input int n);
    if (n == FLEN) return 2'b00;
    if (n < FLEN) return 2'b01;
    return 2'b10;
  endfunction

  // Strobe low just ahead of and through the falling edge of clk.
  task automatic strobe_word(input logic [DW-1:0] w);
    @(posedge clk); #3;
    dstb = 1'b0;
    data_in = w;
    @(negedge clk); #1;
    dstb = 1'b1;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    trsf = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Sends n words; the frame model is updated only when the frame is accepted.
  task automatic send_words(input int n, input bit rnd, input bit gaps, input bit upd);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom) : DW'(16'h0100 + i);
      if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
      strobe_word(w);
      sent_q.push_back(w);
      if (upd && i < 32) model_mem[i] = w;
    end
  endtask

  task automatic run_frame(input int n, input bit rnd, input bit gaps, input bit upd);
    sent_q.delete();
    start_frame();
    send_words(n, rnd, gaps, upd);
    trsf = 1'b1;
  endtask

  task automatic read_word(input logic [4:0] a, output logic [DW-1:0] d);
    @(posedge clk); #1;
    rd_addr = a;
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic do_ack();
    @(posedge clk); #1;
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", frame_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", frame_err); end
    n_tests++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_code: got %0b expected 00", err_code); end
    n_tests++; if (word_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", word_count); end
  endtask

  task automatic test_nominal();
    logic [DW-1:0] d;
    run_frame(FLEN, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_early_valid: got %0b expected 0", frame_valid); end
    @(posedge clk); #1;
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL nominal_valid: got %0b expected 1", frame_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL nominal_err: got %0b expected 0", frame_err); end
    n_tests++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL nominal_code: got %0b expected 00", err_code); end
    n_tests++; if (word_count !== 6'd30) begin n_fail++; $display("FAIL nominal_count: got %0d expected 30", word_count); end
    read_word(5'd5, d);
    n_tests++; if (d !== 16'h0105) begin n_fail++; $display("FAIL nominal_rd5: got %h expected 0105", d); end
    read_word(5'd29, d);
    n_tests++; if (d !== 16'h011D) begin n_fail++; $display("FAIL nominal_rd29: got %h expected 011d", d); end
    do_ack();
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_ack_valid: got %0b expected 0", frame_valid); end
  endtask

  task automatic test_random_frames();
    int n;
    logic [DW-1:0] d;
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0:       n = FLEN;
        1:       n = int'($urandom_range(1, FLEN - 1));
        default: n = int'($urandom_range(FLEN + 1, 40));
      endcase
      run_frame(n, 1'b1, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (frame_valid !== (n == FLEN)) begin n_fail++; $display("FAIL rand_valid n=%0d: got %0b expected %0b", n, frame_valid, n == FLEN); end
      n_tests++; if (frame_err !== (n != FLEN)) begin n_fail++; $display("FAIL rand_err n=%0d: got %0b expected %0b", n, frame_err, n != FLEN); end
      n_tests++; if (err_code !== exp_code(n)) begin n_fail++; $display("FAIL rand_code n=%0d: got %0b expected %0b", n, err_code, exp_code(n)); end
      n_tests++; if (word_count !== 6'(n)) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", word_count, n); end
      for (int a = 0; a < 32; a++) begin
        read_word(5'(a), d);
        n_tests++; if (d !== model_mem[a]) begin n_fail++; $display("FAIL rand_mem[%0d] n=%0d: got %h expected %h", a, n, d, model_mem[a]); end
      end
      do_ack();
      n_tests++; if ({frame_valid, frame_err, err_code} !== 4'b0) begin n_fail++; $display("FAIL rand_ack: got %b expected 0000", {frame_valid, frame_err, err_code}); end
    end
  endtask

  task automatic test_short();
    run_frame(20, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %0b expected 1", frame_err); end
    n_tests++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL short_code: got %0b expected 01", err_code); end
    n_tests++; if (word_count !== 6'd20) begin n_fail++; $display("FAIL short_count: got %0d expected 20", word_count); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL short_valid: got %0b expected 0", frame_valid); end
    do_ack();
  endtask

  task automatic test_long();
    logic [DW-1:0] d;
    run_frame(34, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL long_code: got %0b expected 10", err_code); end
    n_tests++; if (word_count !== 6'd34) begin n_fail++; $display("FAIL long_count: got %0d expected 34", word_count); end
    read_word(5'd31, d);
    n_tests++; if (d !== sent_q[31]) begin n_fail++; $display("FAIL long_rd31: got %h expected %h", d, sent_q[31]); end
    read_word(5'd0, d);
    n_tests++; if (d !== sent_q[0]) begin n_fail++; $display("FAIL long_rd0: got %h expected %h", d, sent_q[0]); end
    read_word(5'd1, d);
    n_tests++; if (d !== sent_q[1]) begin n_fail++; $display("FAIL long_rd1: got %h expected %h", d, sent_q[1]); end
    do_ack();
  endtask

  task automatic test_timeout();
    sent_q.delete();
    start_frame();
    send_words(10, 1'b1, 1'b0, 1'b1);
    @(posedge clk);  // last word accepted here
    repeat (63) @(posedge clk);
    #1;
    n_tests++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL timeout_early: got %0b expected 00", err_code); end
    @(posedge clk); #1;
    n_tests++; if (err_code !== 2'b11) begin n_fail++; $display("FAIL timeout_code: got %0b expected 11", err_code); end
    @(posedge clk); #1;
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %0b expected 1", frame_err); end
    n_tests++; if (word_count !== 6'd10) begin n_fail++; $display("FAIL timeout_count: got %0d expected 10", word_count); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_valid: got %0b expected 0", frame_valid); end
    trsf = 1'b1;
    repeat (3) @(posedge clk);
    do_ack();
  endtask

  task automatic test_overrun();
    logic [DW-1:0] d;
    run_frame(FLEN, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_first_valid: got %0b expected 1", frame_valid); end
    run_frame(FLEN, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_held_valid: got %0b expected 1", frame_valid); end
    n_tests++; if (word_count !== 6'd30) begin n_fail++; $display("FAIL overrun_count: got %0d expected 30", word_count); end
    for (int a = 0; a < 32; a++) begin
      read_word(5'(a), d);
      n_tests++; if (d !== model_mem[a]) begin n_fail++; $display("FAIL overrun_mem[%0d]: got %h expected %h", a, d, model_mem[a]); end
    end
    do_ack();
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_ack: got %0b expected 0", frame_valid); end
    run_frame(FLEN, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL third_valid: got %0b expected 1", frame_valid); end
    for (int a = 0; a < 32; a++) begin
      read_word(5'(a), d);
      n_tests++; if (d !== model_mem[a]) begin n_fail++; $display("FAIL third_mem[%0d]: got %h expected %h", a, d, model_mem[a]); end
    end
    do_ack();
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] d;
    sent_q.delete();
    start_frame();
    send_words(12, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %0b expected 0", frame_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_err: got %0b expected 0", frame_err); end
    n_tests++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL midreset_code: got %0b expected 00", err_code); end
    n_tests++; if (word_count !== 6'd0) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", word_count); end
    trsf = 1'b1;
    repeat (3) @(posedge clk);
    run_frame(FLEN, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL postreset_valid: got %0b expected 1", frame_valid); end
    n_tests++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL postreset_code: got %0b expected 00", err_code); end
    n_tests++; if (word_count !== 6'd30) begin n_fail++; $display("FAIL postreset_count: got %0d expected 30", word_count); end
    for (int a = 0; a < 32; a++) begin
      read_word(5'(a), d);
      n_tests++; if (d !== model_mem[a]) begin n_fail++; $display("FAIL postreset_mem[%0d]: got %h expected %h", a, d, model_mem[a]); end
    end
    do_ack();
  endtask

  initial begin
    reset     = 1'b0;
    trsf      = 1'b1;
    dstb      = 1'b1;
    frame_ack = 1'b0;
    data_in   = '0;
    rd_addr   = '0;
    test_reset();
    test_nominal();
    test_random_frames();
    test_short();
    test_long();
    test_timeout();
    test_overrun();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
